// File: rtl/sd_dac_pkg.sv
// Shared constants, sample struct and LFSR helpers for the dual sigma-delta DAC.
// SD_DAC_DITHER_EN enables the LFSR dither path in sd_dac_xy.
package sd_dac_pkg;

  localparam int SD_WIDTH    = 8;
  localparam int SD_OSR_LOG2 = 5;
  localparam int FRAME_LEN   = 1 << SD_OSR_LOG2;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [SD_WIDTH-1:0] x;
    logic [SD_WIDTH-1:0] y;
  } xy_code_t;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // lfsr[1:0] - 2 as a 2-bit signed value
  function automatic logic signed [1:0] dither_of(
    input logic [1:0] b
  );
    return {~b[1], b[0]};
  endfunction

endpackage

// File: rtl/sd_mod_ch.sv
// Single-channel first-order sigma-delta modulator.
// Accumulator plus registered carry; optional signed dither with clamping.
module sd_mod_ch
  import sd_dac_pkg::*;
#(
  parameter int WIDTH = SD_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  code,
  input  logic signed [1:0] dither,
  output logic              sd
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   sat;

  // Top bit set only when dither pulls the sum below zero
  always_comb begin
    sum = {2'b00, acc_q}
        + {2'b00, code}
        + {{WIDTH{dither[1]}}, dither};
    sat = sum[WIDTH+1] ? '0 : sum[WIDTH:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      sd    <= 1'b0;
    end else begin
      {sd, acc_q} <= sat;
    end
  end

endmodule

// File: rtl/sd_dac_xy.sv
// Two-channel sigma-delta DAC with a one-entry valid/ready sample buffer.
// Define SD_DAC_DITHER_EN to add LFSR dither to both modulators.
module sd_dac_xy
  import sd_dac_pkg::*;
#(
  parameter int WIDTH    = SD_WIDTH,
  parameter int OSR_LOG2 = SD_OSR_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             x_sd,
  output logic             y_sd,
  output logic             frame_tick,
  output logic             underrun
);

  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;

  logic [OSR_LOG2-1:0] cnt_q;
  logic                boundary;
  logic                accept;
  logic                full_q;
  xy_code_t            pend_q;
  xy_code_t            act_q;
  logic signed [1:0]   dither;

`ifdef SD_DAC_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign dither = dither_of(lfsr_q[1:0]);
`else
  assign dither = 2'sd0;
`endif

  assign boundary     = (cnt_q == CNT_LAST);
  assign sample_ready = !full_q;
  assign accept       = sample_valid && !full_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + OSR_LOG2'(1);
    end
  end

  // Accept only happens when empty and the swap only when full,
  // so the two full_q writes never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q     <= 1'b0;
      pend_q     <= '0;
      act_q      <= '0;
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_tick <= boundary && full_q;
      underrun   <= boundary && !full_q;
      if (boundary && full_q) begin
        act_q  <= pend_q;
        full_q <= 1'b0;
      end
      if (accept) begin
        pend_q <= {x_in, y_in};
        full_q <= 1'b1;
      end
    end
  end

  sd_mod_ch #(
    .WIDTH(WIDTH)
  ) u_x (
    .clk   (clk),
    .reset (reset),
    .code  (act_q.x),
    .dither(dither),
    .sd    (x_sd)
  );

  sd_mod_ch #(
    .WIDTH(WIDTH)
  ) u_y (
    .clk   (clk),
    .reset (reset),
    .code  (act_q.y),
    .dither(dither),
    .sd    (y_sd)
  );

endmodule
